// File: rtl/double_sub_scheduler_if.sv
// Bundle of the scheduler's request/result matrices and its shared fp_sub connection.
interface double_sub_scheduler_if #(
  parameter int unsigned SIZE_A = 8,
  parameter int unsigned SIZE_B = 8
);
  // Request / result side
  logic        start;
  logic [63:0] mat_a   [SIZE_A][SIZE_B];
  logic [63:0] mat_b   [SIZE_A][SIZE_B];
  logic [63:0] mat_out [SIZE_A][SIZE_B];
  logic        busy;
  logic        done;
  logic [3:0]  err_flags;

  // Shared fp_sub core side
  logic [63:0] sub_a;
  logic [63:0] sub_b;
  logic        sub_en;
  logic [63:0] sub_result;
  logic        sub_nan;
  logic        sub_of;
  logic        sub_uf;
  logic        sub_zero;

  // Scheduler view
  modport slave (
    input  start, mat_a, mat_b, sub_result, sub_nan, sub_of, sub_uf, sub_zero,
    output mat_out, busy, done, err_flags, sub_a, sub_b, sub_en
  );

  // Requester / fp_sub model view
  modport master (
    output start, mat_a, mat_b, sub_result, sub_nan, sub_of, sub_uf, sub_zero,
    input  mat_out, busy, done, err_flags, sub_a, sub_b, sub_en
  );
endinterface

// File: rtl/double_sub_scheduler.sv
// Time-multiplexes one pipelined double-precision fp_sub over a SIZE_A x SIZE_B
// matrix: mat_out = mat_a - mat_b, one element issued per cycle, row-major.
module double_sub_scheduler #(
  parameter int unsigned SIZE_A = 8,
  parameter int unsigned SIZE_B = 8,
  parameter int unsigned CYCLES = 7
) (
  input logic                   clk,
  input logic                   rst,
  double_sub_scheduler_if.slave bus
);

  localparam int unsigned N     = SIZE_A * SIZE_B;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [CNT_W-1:0]  wb_cnt_q;
  logic [CYCLES-1:0] valid_sr_q;
  logic [63:0]       a_q       [N];
  logic [63:0]       b_q       [N];
  logic [63:0]       mat_out_q [N];
  logic [63:0]       sub_a_q;
  logic [63:0]       sub_b_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        err_q;

  logic              wb_valid_c;
  logic              wb_last_c;
  logic              issue_last_c;

  // A result is due from fp_sub when the oldest valid bit comes out of the shift register.
  assign wb_valid_c   = valid_sr_q[CYCLES-1];
  assign wb_last_c    = wb_valid_c && (wb_cnt_q == CNT_W'(N - 1));
  assign issue_last_c = (issue_cnt_q == CNT_W'(N));

  // Control FSM, operand issue, valid pipeline and result writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      wb_cnt_q    <= '0;
      valid_sr_q  <= '0;
      sub_a_q     <= '0;
      sub_b_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      for (int k = 0; k < int'(N); k++) begin
        a_q[k]       <= '0;
        b_q[k]       <= '0;
        mat_out_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      // The valid pipeline advances every cycle; it never stalls mid-run.
      for (int k = int'(CYCLES) - 1; k > 0; k--) begin
        valid_sr_q[k] <= valid_sr_q[k-1];
      end
      valid_sr_q[0] <= (state_q == ISSUE);

      if (wb_valid_c) begin
        mat_out_q[IDX_W'(wb_cnt_q)] <= bus.sub_result;
        err_q <= err_q | {bus.sub_nan, bus.sub_of, bus.sub_uf, bus.sub_zero};
        if (wb_cnt_q != CNT_W'(N)) begin
          wb_cnt_q <= wb_cnt_q + CNT_W'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < int'(SIZE_A); i++) begin
              for (int j = 0; j < int'(SIZE_B); j++) begin
                a_q[i*int'(SIZE_B) + j]       <= bus.mat_a[i][j];
                b_q[i*int'(SIZE_B) + j]       <= bus.mat_b[i][j];
                mat_out_q[i*int'(SIZE_B) + j] <= '0;
              end
            end
            // Element 0 goes straight onto the core so it is issued in the first busy cycle.
            sub_a_q     <= bus.mat_a[0][0];
            sub_b_q     <= bus.mat_b[0][0];
            issue_cnt_q <= CNT_W'(1);
            wb_cnt_q    <= '0;
            err_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_last_c) begin
            state_q <= DRAIN;
          end else begin
            sub_a_q     <= a_q[IDX_W'(issue_cnt_q)];
            sub_b_q     <= b_q[IDX_W'(issue_cnt_q)];
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (wb_last_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Registered outputs onto the bus.
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_flags = err_q;
  assign bus.sub_a     = sub_a_q;
  assign bus.sub_b     = sub_b_q;
  assign bus.sub_en    = busy_q;

  // Row-major flat result storage mapped back to the matrix view.
  for (genvar gi = 0; gi < int'(SIZE_A); gi++) begin : g_row
    for (genvar gj = 0; gj < int'(SIZE_B); gj++) begin : g_col
      assign bus.mat_out[gi][gj] = mat_out_q[gi*int'(SIZE_B) + gj];
    end
  end

endmodule

// File: tb/tb_double_sub_scheduler.sv
// Directed bench for double_sub_scheduler: 2x2 and 8x8 instances, each with its own
// behavioural fp_sub pipeline; expected results go through a scoreboard queue.
module tb_double_sub_scheduler;

  localparam int unsigned CYC = 7;
  localparam int unsigned N2  = 4;
  localparam int unsigned N8  = 64;

  typedef logic [63:0] m4_t [4];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb_q  [$];
  logic [3:0]  err_q [$];

  double_sub_scheduler_if #(.SIZE_A(2), .SIZE_B(2)) bus2 ();
  double_sub_scheduler_if #(.SIZE_A(8), .SIZE_B(8)) bus8 ();

  double_sub_scheduler #(.SIZE_A(2), .SIZE_B(2), .CYCLES(CYC)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  double_sub_scheduler #(.SIZE_A(8), .SIZE_B(8), .CYCLES(CYC)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  function automatic logic [63:0] fsub(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) - $bitstoreal(b));
  endfunction

  // {nan, overflow, underflow, zero} classification of a result
  function automatic logic [3:0] fflags(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] r);
    logic nan, ovf, unf, zro;
    nan = (r[62:52] == 11'h7FF) && (r[51:0] != 52'd0);
    ovf = (r[62:52] == 11'h7FF) && (r[51:0] == 52'd0) &&
          (a[62:52] != 11'h7FF) && (b[62:52] != 11'h7FF);
    unf = (r[62:52] == 11'd0) && (r[51:0] != 52'd0);
    zro = (r[62:0] == 63'd0);
    return {nan, ovf, unf, zro};
  endfunction

  // Behavioural fp_sub cores: CYC-stage pipelines gated by sub_en
  logic [63:0] p2_r [CYC];
  logic [3:0]  p2_f [CYC];
  logic [63:0] p8_r [CYC];
  logic [3:0]  p8_f [CYC];

  always @(posedge clk) begin
    if (bus2.sub_en) begin
      for (int k = int'(CYC) - 1; k > 0; k--) begin
        p2_r[k] <= p2_r[k-1];
        p2_f[k] <= p2_f[k-1];
      end
      p2_r[0] <= fsub(bus2.sub_a, bus2.sub_b);
      p2_f[0] <= fflags(bus2.sub_a, bus2.sub_b, fsub(bus2.sub_a, bus2.sub_b));
    end
  end

  always @(posedge clk) begin
    if (bus8.sub_en) begin
      for (int k = int'(CYC) - 1; k > 0; k--) begin
        p8_r[k] <= p8_r[k-1];
        p8_f[k] <= p8_f[k-1];
      end
      p8_r[0] <= fsub(bus8.sub_a, bus8.sub_b);
      p8_f[0] <= fflags(bus8.sub_a, bus8.sub_b, fsub(bus8.sub_a, bus8.sub_b));
    end
  end

  assign bus2.sub_result = p2_r[CYC-1];
  assign {bus2.sub_nan, bus2.sub_of, bus2.sub_uf, bus2.sub_zero} = p2_f[CYC-1];
  assign bus8.sub_result = p8_r[CYC-1];
  assign {bus8.sub_nan, bus8.sub_of, bus8.sub_uf, bus8.sub_zero} = p8_f[CYC-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard against a matrix presented as a flat row-major list
  task automatic sb_check2(input string tag);
    logic [63:0] e;
    for (int k = 0; k < int'(N2); k++) begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
      chk($sformatf("%s_out%0d", tag, k), bus2.mat_out[k/2][k%2], e);
    end
    chk({tag, "_err"}, 64'(bus2.err_flags),
        64'((err_q.size() > 0) ? err_q.pop_front() : 4'hF));
  endtask

  task automatic sb_check8(input string tag);
    logic [63:0] e;
    for (int k = 0; k < int'(N8); k++) begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
      chk($sformatf("%s_out%0d", tag, k), bus8.mat_out[k/8][k%8], e);
    end
    chk({tag, "_err"}, 64'(bus8.err_flags),
        64'((err_q.size() > 0) ? err_q.pop_front() : 4'hF));
  endtask

  // One full 2x2 run; start is accepted on the edge ending the first driven cycle (edge 0)
  task automatic run2(input string tag, input m4_t a, input m4_t b,
                      input bit repulse, input bit chg_a, input bit chk_busy);
    int          done_cnt;
    int          done_cyc;
    logic [3:0]  e;
    logic [63:0] r;
    done_cnt = 0;
    done_cyc = 0;
    e        = '0;
    @(negedge clk);
    for (int k = 0; k < int'(N2); k++) begin
      bus2.mat_a[k/2][k%2] = a[k];
      bus2.mat_b[k/2][k%2] = b[k];
      r = fsub(a[k], b[k]);
      sb_q.push_back(r);
      e = e | fflags(a[k], b[k], r);
    end
    err_q.push_back(e);
    bus2.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      bus2.start = repulse && (c == 3 || c == 12);
      if (chg_a && c == 2) begin
        for (int k = 0; k < int'(N2); k++) bus2.mat_a[k/2][k%2] = $realtobits(9.0);
      end
      if (c == 1) chk({tag, "_errclr"}, 64'(bus2.err_flags), 64'd0);
      if (chk_busy && c <= 13) chk($sformatf("%s_busy_c%0d", tag, c), 64'(bus2.busy), 64'(c <= 11));
      if (bus2.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = c;
          sb_check2(tag);
        end
      end
    end
    chk({tag, "_ndone"}, 64'(done_cnt), 64'd1);
    chk({tag, "_donecyc"}, 64'(done_cyc), 64'(N2 + CYC + 1));
  endtask

  // One 8x8 run with random finite doubles; returns right after the done pulse
  task automatic run8(input string tag);
    logic [63:0] av, bv, r;
    logic [3:0]  e;
    int          done_cyc;
    e        = '0;
    done_cyc = 0;
    @(negedge clk);
    for (int k = 0; k < int'(N8); k++) begin
      av = {1'($urandom), 11'(1003 + $urandom_range(0, 40)), 52'({$urandom, $urandom})};
      bv = {1'($urandom), 11'(1003 + $urandom_range(0, 40)), 52'({$urandom, $urandom})};
      bus8.mat_a[k/8][k%8] = av;
      bus8.mat_b[k/8][k%8] = bv;
      r = fsub(av, bv);
      sb_q.push_back(r);
      e = e | fflags(av, bv, r);
    end
    err_q.push_back(e);
    bus8.start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      // Scramble the inputs mid-run: the latched copies must be used
      if (c == 3) begin
        for (int k = 0; k < int'(N8); k++) bus8.mat_a[k/8][k%8] = 64'(k);
      end
      if (bus8.done) begin
        done_cyc = c;
        sb_check8(tag);
        break;
      end
    end
    chk({tag, "_donecyc"}, 64'(done_cyc), 64'(N8 + CYC + 1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    m4_t a_base, b_ones, a_inf, b_inf;
    int  done_cnt;
    logic [63:0] mz;

    a_base = '{$realtobits(5.0), $realtobits(4.0), $realtobits(3.0), $realtobits(2.0)};
    b_ones = '{$realtobits(1.0), $realtobits(1.0), $realtobits(1.0), $realtobits(1.0)};
    a_inf  = '{$realtobits(5.0), $realtobits(4.0), 64'h7FF0_0000_0000_0000, $realtobits(2.0)};
    b_inf  = '{$realtobits(1.0), $realtobits(1.0), 64'h7FF0_0000_0000_0000, $realtobits(1.0)};

    rst        = 1'b0;
    bus2.start = 1'b0;
    bus8.start = 1'b0;
    for (int k = 0; k < int'(N2); k++) begin
      bus2.mat_a[k/2][k%2] = '0;
      bus2.mat_b[k/2][k%2] = '0;
    end
    for (int k = 0; k < int'(N8); k++) begin
      bus8.mat_a[k/8][k%8] = '0;
      bus8.mat_b[k/8][k%8] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_busy",  64'(bus2.busy),      64'd0);
    chk("rst_done",  64'(bus2.done),      64'd0);
    chk("rst_err",   64'(bus2.err_flags), 64'd0);
    chk("rst_suben", 64'(bus2.sub_en),    64'd0);
    chk("rst_suba",  bus2.sub_a,          64'd0);
    chk("rst_out3",  bus2.mat_out[1][1],  64'd0);
    chk("rst_busy8", 64'(bus8.busy),      64'd0);

    // Basic 2x2 run with cycle-exact busy/done
    run2("base", a_base, b_ones, 1'b0, 1'b0, 1'b1);
    // Start re-pulsed during busy and during DONE, mat_a changed mid-run
    run2("repulse", a_base, b_ones, 1'b1, 1'b1, 1'b0);
    // +inf - +inf at element (1,0): nan flag sticky after done
    run2("nan", a_inf, b_inf, 1'b0, 1'b0, 1'b0);
    chk("nan_held", 64'(bus2.err_flags), 64'h8);
    // Following run starts from cleared flags
    run2("clr", a_base, b_ones, 1'b0, 1'b0, 1'b0);

    // Reset asserted in cycle 6 of a run
    @(negedge clk);
    for (int k = 0; k < int'(N2); k++) begin
      bus2.mat_a[k/2][k%2] = a_base[k];
      bus2.mat_b[k/2][k%2] = b_ones[k];
    end
    bus2.start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus2.start = 1'b0;
    end
    chk("mid_busy_pre", 64'(bus2.busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_busy",  64'(bus2.busy),      64'd0);
    chk("mid_done",  64'(bus2.done),      64'd0);
    chk("mid_err",   64'(bus2.err_flags), 64'd0);
    chk("mid_suben", 64'(bus2.sub_en),    64'd0);
    chk("mid_suba",  bus2.sub_a,          64'd0);
    chk("mid_subb",  bus2.sub_b,          64'd0);
    mz = '0;
    for (int k = 0; k < int'(N2); k++) mz = mz | bus2.mat_out[k/2][k%2];
    chk("mid_out", mz, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus2.done) done_cnt++;
    end
    chk("mid_nodone", 64'(done_cnt), 64'd0);
    run2("post_rst", a_base, b_ones, 1'b0, 1'b0, 1'b0);

    // Two back-to-back 8x8 random runs
    run8("r8a");
    run8("r8b");

    chk("sb_empty",  64'(sb_q.size()),  64'd0);
    chk("err_empty", 64'(err_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
